ex_mem_stage: RTL and testbench

- EX/MEM pipeline register for the MIPS pipeline. Sits directly downstream of the execute-stage ALU.
- Captures the ALU result, the multiply high word and branch_taken, together with the control fields that travel alongside them.
- Owns the architectural HI/LO registers.
- Generates the registered branch redirect to fetch.
- Runs the halt sequencing FSM, with a valid/ready style stall handshake to the memory stage.

---
 rtl/ex_mem_stage.sv | 121 ++++++++++++
 tb/tb_ex_mem_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and control, owns HI/LO,
// issues the registered branch redirect and sequences HALT through a drain.
module ex_mem_stage #(
  parameter int          WIDTH   = 32,
  parameter int          RA_W    = 5,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_op_sel,
  input  logic [WIDTH-1:0]  ex_result,
  input  logic [WIDTH-1:0]  ex_result_h,
  input  logic              ex_branch_taken,
  input  logic              ex_is_branch,
  input  logic [WIDTH-1:0]  ex_branch_target,
  input  logic              ex_hilo_write,
  input  logic [1:0]        ex_hilo_sel,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [WIDTH-1:0]  ex_store_data,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              mem_valid,
  output logic [WIDTH-1:0]  mem_result,
  output logic [RA_W-1:0]   mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic [WIDTH-1:0]  mem_store_data,
  output logic [WIDTH-1:0]  hi_q,
  output logic [WIDTH-1:0]  lo_q,
  output logic              redirect_valid,
  output logic [WIDTH-1:0]  redirect_pc,
  output logic              halted,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;

  logic             capture;
  logic             is_halt;
  logic [WIDTH-1:0] sel_result;

  // Handshake: EX data moves when ex_valid && ex_ready; ex_ready drops while
  // the memory stage stalls or once a HALT has been accepted.
  assign ex_ready = (state == RUN) && !mem_stall;
  assign capture  = ex_ready && ex_valid && !flush;
  assign is_halt  = (ex_op_sel == HALT_OP);

  always_comb begin
    sel_result = ex_result;
    case (ex_hilo_sel)
      2'b01:   sel_result = lo_q;
      2'b10:   sel_result = hi_q;
      default: sel_result = ex_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      halted         <= 1'b0;
      instr_count    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        RUN: begin
          if (capture) begin
            mem_valid      <= 1'b1;
            mem_result     <= sel_result;
            mem_rd         <= ex_rd;
            // A HALT travels down as an inert bubble-like instruction.
            mem_reg_write  <= ex_reg_write && !is_halt;
            mem_mem_read   <= ex_mem_read && !is_halt;
            mem_mem_write  <= ex_mem_write && !is_halt;
            mem_store_data <= ex_store_data;
            instr_count    <= instr_count + 32'd1;
            if (ex_hilo_write) begin
              hi_q <= ex_result_h;
              lo_q <= ex_result;
            end
            if (ex_is_branch && ex_branch_taken) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= ex_branch_target;
            end
            if (is_halt) state <= DRAIN;
          end else if (!mem_stall) begin
            mem_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            mem_valid <= 1'b0;
            halted    <= 1'b1;
            state     <= HALTED;
          end
        end
        HALTED: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table plus hand sequences for stall, halt
// and asynchronous reset, checked through an expected-result queue.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [5:0]  ex_op_sel;
  logic [31:0] ex_result, ex_result_h, ex_branch_target, ex_store_data;
  logic        ex_branch_taken, ex_is_branch, ex_hilo_write;
  logic [1:0]  ex_hilo_sel;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        flush, mem_stall;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [31:0] mem_result, mem_store_data, hi_q, lo_q, redirect_pc, instr_count;
  logic [4:0]  mem_rd;
  logic        redirect_valid, halted;

  localparam logic [5:0] HALT = 6'b111111;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op_sel(ex_op_sel), .ex_result(ex_result), .ex_result_h(ex_result_h),
    .ex_branch_taken(ex_branch_taken), .ex_is_branch(ex_is_branch),
    .ex_branch_target(ex_branch_target), .ex_hilo_write(ex_hilo_write),
    .ex_hilo_sel(ex_hilo_sel), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .flush(flush), .mem_stall(mem_stall),
    .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data),
    .hi_q(hi_q), .lo_q(lo_q), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .instr_count(instr_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mv;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] sd;
    logic        rv;
    logic [31:0] rpc, hi, lo, cnt;
    logic        hlt;
  } exp_t;

  localparam int EW = $bits(exp_t);

  typedef struct {
    logic        valid, flsh, stall;
    logic [5:0]  op;
    logic [31:0] res, res_h;
    logic [1:0]  sel;
    logic        hw, br, taken;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [31:0] sd;
    logic        e_ready;
    exp_t        exp;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  vec_t tbl[12];

  logic [31:0] hi_m, lo_m, rpc_m, cnt_m;

  function automatic vec_t v_in(logic valid, logic flsh, logic stall, logic [5:0] op,
                                logic [31:0] res, logic [31:0] res_h, logic [1:0] sel,
                                logic hw, logic br, logic taken, logic [31:0] tgt,
                                logic [4:0] rd, logic rw, logic mr, logic mw,
                                logic [31:0] sd);
    vec_t v;
    v.valid = valid; v.flsh = flsh; v.stall = stall; v.op = op;
    v.res = res; v.res_h = res_h; v.sel = sel; v.hw = hw; v.br = br;
    v.taken = taken; v.tgt = tgt; v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
    v.sd = sd; v.e_ready = !stall; v.exp = '0;
    return v;
  endfunction

  function automatic exp_t ex(logic mv, logic [31:0] res, logic [4:0] rd, logic rw,
                              logic mr, logic mw, logic [31:0] sd, logic rv,
                              logic [31:0] rpc, logic [31:0] hi, logic [31:0] lo,
                              logic [31:0] cnt, logic hlt);
    exp_t e;
    e.mv = mv; e.res = res; e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw;
    e.sd = sd; e.rv = rv; e.rpc = rpc; e.hi = hi; e.lo = lo; e.cnt = cnt;
    e.hlt = hlt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // scoreboard: pop one expected record per clock and compare
  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = exp_t'(exp_q.pop_front());
    chk1("mem_valid", mem_valid, e.mv);
    if (e.mv) begin
      chk("mem_result", mem_result, e.res);
      chk("mem_rd", {27'b0, mem_rd}, {27'b0, e.rd});
      chk1("mem_reg_write", mem_reg_write, e.rw);
      chk1("mem_mem_read", mem_mem_read, e.mr);
      chk1("mem_mem_write", mem_mem_write, e.mw);
      chk("mem_store_data", mem_store_data, e.sd);
    end
    chk1("redirect_valid", redirect_valid, e.rv);
    chk("redirect_pc", redirect_pc, e.rpc);
    chk("hi_q", hi_q, e.hi);
    chk("lo_q", lo_q, e.lo);
    chk("instr_count", instr_count, e.cnt);
    chk1("halted", halted, e.hlt);
  endtask

  // driver: called just after a rising edge, drives one cycle of stimulus
  task automatic apply(input vec_t v);
    ex_valid = v.valid; flush = v.flsh; mem_stall = v.stall; ex_op_sel = v.op;
    ex_result = v.res; ex_result_h = v.res_h; ex_hilo_sel = v.sel;
    ex_hilo_write = v.hw; ex_is_branch = v.br; ex_branch_taken = v.taken;
    ex_branch_target = v.tgt; ex_rd = v.rd; ex_reg_write = v.rw;
    ex_mem_read = v.mr; ex_mem_write = v.mw; ex_store_data = v.sd;
    exp_q.push_back(v.exp);
    #1;
    chk1("ex_ready", ex_ready, v.e_ready);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle_inputs();
    ex_valid = 0; flush = 0; mem_stall = 0; ex_op_sel = 0; ex_result = 0;
    ex_result_h = 0; ex_hilo_sel = 0; ex_hilo_write = 0; ex_is_branch = 0;
    ex_branch_taken = 0; ex_branch_target = 0; ex_rd = 0; ex_reg_write = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_store_data = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_mem_valid"}, mem_valid, 1'b0);
    chk({tag, "_mem_result"}, mem_result, 32'h0);
    chk({tag, "_mem_rd"}, {27'b0, mem_rd}, 32'h0);
    chk1({tag, "_mem_reg_write"}, mem_reg_write, 1'b0);
    chk({tag, "_mem_store_data"}, mem_store_data, 32'h0);
    chk1({tag, "_redirect_valid"}, redirect_valid, 1'b0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    chk({tag, "_hi_q"}, hi_q, 32'h0);
    chk({tag, "_lo_q"}, lo_q, 32'h0);
    chk({tag, "_instr_count"}, instr_count, 32'h0);
    chk1({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [31:0] r, s;
    logic [4:0]  d;
    logic        f;

    // vector table: inputs and hand-computed outputs after each edge
    tbl[0]  = v_in(1,0,0,6'h21, 32'h5, 0, 2'b00,0, 0,0,0, 5'd3,1,0,0, 0);
    tbl[0].exp  = ex(1, 32'h5, 5'd3,1,0,0, 0, 0,0, 0,0, 1, 0);
    tbl[1]  = v_in(1,0,0,6'h19, 32'h1, 32'hFFFF_FFFE, 2'b00,1, 0,0,0, 5'd0,0,0,0, 0);
    tbl[1].exp  = ex(1, 32'h1, 5'd0,0,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 2, 0);
    tbl[2]  = v_in(1,0,0,6'h12, 32'hDEAD, 0, 2'b01,0, 0,0,0, 5'd4,1,0,0, 0);
    tbl[2].exp  = ex(1, 32'h1, 5'd4,1,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 3, 0);
    tbl[3]  = v_in(1,0,0,6'h10, 32'hBEEF, 0, 2'b10,0, 0,0,0, 5'd5,1,0,0, 0);
    tbl[3].exp  = ex(1, 32'hFFFF_FFFE, 5'd5,1,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 4, 0);
    tbl[4]  = v_in(1,0,0,6'h21, 32'h77, 0, 2'b11,0, 0,0,0, 5'd6,1,0,0, 0);
    tbl[4].exp  = ex(1, 32'h77, 5'd6,1,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 5, 0);
    tbl[5]  = v_in(1,0,0,6'h2B, 32'h1000, 0, 2'b00,0, 0,0,0, 5'd0,0,0,1, 32'hCAFE_BABE);
    tbl[5].exp  = ex(1, 32'h1000, 5'd0,0,0,1, 32'hCAFE_BABE, 0,0, 32'hFFFF_FFFE,1, 6, 0);
    tbl[6]  = v_in(1,0,0,6'h23, 32'h2000, 0, 2'b00,0, 0,0,0, 5'd8,1,1,0, 0);
    tbl[6].exp  = ex(1, 32'h2000, 5'd8,1,1,0, 0, 0,0, 32'hFFFF_FFFE,1, 7, 0);
    tbl[7]  = v_in(0,0,0,6'h21, 32'h99, 0, 2'b00,0, 0,0,0, 5'd7,1,0,0, 0);
    tbl[7].exp  = ex(0, 0, 0,0,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 7, 0);
    tbl[8]  = v_in(1,1,0,6'h18, 32'h1234, 32'h5, 2'b00,1, 1,1,32'h80, 5'd2,1,0,0, 0);
    tbl[8].exp  = ex(0, 0, 0,0,0,0, 0, 0,0, 32'hFFFF_FFFE,1, 7, 0);
    tbl[9]  = v_in(1,0,0,6'h04, 0, 0, 2'b00,0, 1,1,32'h40, 5'd0,0,0,0, 0);
    tbl[9].exp  = ex(1, 0, 0,0,0,0, 0, 1,32'h40, 32'hFFFF_FFFE,1, 8, 0);
    tbl[10] = v_in(1,0,0,6'h04, 0, 0, 2'b00,0, 1,0,32'h100, 5'd0,0,0,0, 0);
    tbl[10].exp = ex(1, 0, 0,0,0,0, 0, 0,32'h40, 32'hFFFF_FFFE,1, 9, 0);
    tbl[11] = v_in(1,0,0,6'h21, 32'h3, 0, 2'b00,0, 0,1,32'h200, 5'd1,1,0,0, 0);
    tbl[11].exp = ex(1, 32'h3, 5'd1,1,0,0, 0, 0,32'h40, 32'hFFFF_FFFE,1, 10, 0);

    // reset
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk_all_zero("reset");
    chk1("reset_ex_ready", ex_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i]);
    hi_m = 32'hFFFF_FFFE; lo_m = 32'h1; rpc_m = 32'h40; cnt_m = 32'd10;

    // taken branch then 3 stall cycles: one redirect pulse, fields held
    v = v_in(1,0,0,6'h04, 32'hAB, 0, 2'b00,0, 1,1,32'h40, 5'd9,1,0,0, 0);
    cnt_m++;
    v.exp = ex(1, 32'hAB, 5'd9,1,0,0, 0, 1,rpc_m, hi_m,lo_m, cnt_m, 0);
    apply(v);
    for (int k = 0; k < 3; k++) begin
      v = v_in(1,0,1,6'h19, 32'h55, 32'h66, 2'b00,1, 1,1,32'h300, 5'd10,1,0,0, 0);
      v.exp = ex(1, 32'hAB, 5'd9,1,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
      apply(v);
    end
    v = v_in(0,0,0,6'h00, 0, 0, 2'b00,0, 0,0,0, 5'd0,0,0,0, 0);
    v.exp = ex(0, 0, 0,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
    apply(v);

    // random ALU traffic with occasional flushes
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      s = $urandom;
      d = 5'($urandom_range(1, 31));
      f = ($urandom_range(0, 3) == 0);
      v = v_in(1,f,0,6'h21, r, 0, 2'b00,0, 0,0,0, d,1,0,0, s);
      if (f) v.exp = ex(0, 0, 0,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
      else begin
        cnt_m++;
        v.exp = ex(1, r, d,1,0,0, s, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
      end
      apply(v);
    end

    // HALT accepted, drains through a 2-cycle stall, then freezes
    v = v_in(1,0,0,HALT, 0, 0, 2'b00,0, 0,0,0, 5'd1,1,1,1, 0);
    cnt_m++;
    v.exp = ex(1, 0, 5'd1,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
    apply(v);
    for (int k = 0; k < 2; k++) begin
      v = v_in(0,0,1,6'h00, 0, 0, 2'b00,0, 0,0,0, 5'd1,0,0,0, 0);
      v.exp = ex(1, 0, 5'd1,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 0);
      apply(v);
    end
    v = v_in(0,0,0,6'h00, 0, 0, 2'b00,0, 0,0,0, 5'd0,0,0,0, 0);
    v.e_ready = 1'b0;
    v.exp = ex(0, 0, 0,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 1);
    apply(v);
    for (int k = 0; k < 3; k++) begin
      v = v_in(1,0,0,6'h21, 32'h9, 32'h8, 2'b00,1, 1,1,32'h500, 5'd2,1,0,0, 0);
      v.e_ready = 1'b0;
      v.exp = ex(0, 0, 0,0,0,0, 0, 0,rpc_m, hi_m,lo_m, cnt_m, 1);
      apply(v);
    end

    // reset leaves HALTED without a clock edge
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk1("halt_reset_halted", halted, 1'b0);
    chk1("halt_reset_ex_ready", ex_ready, 1'b1);
    chk("halt_reset_instr_count", instr_count, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // capture with HI/LO write and redirect, then async reset mid-cycle
    v = v_in(1,0,0,6'h19, 32'h42, 32'h43, 2'b00,1, 1,1,32'h60, 5'd2,1,0,0, 32'h11);
    v.exp = ex(1, 32'h42, 5'd2,1,0,0, 32'h11, 1,32'h60, 32'h43,32'h42, 1, 0);
    apply(v);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async");
    #2;
    rst_n = 1'b1;

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
